// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-only data memory: does sub-word
// extraction/extension on loads, read-modify-write on sub-word stores, and error checks.
module load_store_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wword_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        uns_q;
    logic        err_q;
    logic        accept;
    logic        req_err;

    // Pull the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the read word with the store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {24'b0, wdata[7:0]} << {lane, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                data = {16'b0, wdata[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (word & ~mask) | (data & mask);
    endfunction

    assign accept  = req_valid && (state_q == IDLE);
    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_addr >= ADDR_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wword_q <= req_wdata;
                rdata_q <= '0;
                size_q  <= req_size;
                write_q <= req_write;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
            end
            // READ closing edge: wword_q still holds the raw store data here
            if (state_q == READ) begin
                if (write_q)
                    wword_q <= merge_store(mem_read_data, wword_q, addr_q[1:0], size_q);
                else
                    rdata_q <= extract_load(mem_read_data, addr_q[1:0], size_q, uns_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!req_write || req_size != 2'b10)
                        state_d = READ;
                    else
                        state_d = WRITE;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == IDLE);
        resp_valid     = (state_q == RESP);
        resp_rdata     = (state_q == RESP) ? rdata_q : 32'h0;
        resp_err       = (state_q == RESP) ? err_q : 1'b0;
        mem_read       = (state_q == READ);
        mem_write      = (state_q == WRITE);
        mem_address    = (state_q == READ || state_q == WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_write_data = (state_q == WRITE) ? wword_q : 32'h0;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequencing stage directly upstream of data_memory. It accepts byte, halfword and word load/store requests from the execute stage and drives data_memory's word-only interface. Sub-word stores are done as read-modify-write. Sub-word loads are extracted and extended here. The unit also flags misaligned and out-of-range accesses.

Parameters:
ADDR_LIMIT, 32'h0000_1000, byte-address upper bound (exclusive) of data memory; any access at or above it is an error.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, valid with resp_valid (0 for stores/errors)
resp_err  output  1  misaligned / reserved size / out-of-range, valid with resp_valid
mem_read  output  1  to data_memory read enable
mem_write  output  1  to data_memory write enable
mem_address  output  32  word-aligned address {addr[31:2],2'b00}
mem_write_data  output  32  full word to write
mem_read_data  input  32  asynchronous read data from data_memory

Behaviour:
- Handshake: a request is accepted at a rising edge where req_valid && req_ready. At that edge, addr, wdata, size, write and unsigned are captured. req_valid is ignored when req_ready=0; there is no queueing.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On accept:
  - error → RESP
  - load or sub-word store → READ
  - word store → WRITE
- Error conditions, all checked at accept:
  - size=11
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]≠0
  - addr ≥ ADDR_LIMIT
  - An error performs no memory access: mem_read and mem_write stay 0 for the whole transaction.
- READ (1 cycle): mem_read=1, mem_address valid. At the closing edge, mem_read_data is registered.
  - Load → RESP, with the result computed into resp_rdata.
  - Sub-word store → WRITE, with the merged word registered.
- Little-endian byte order: byte lane k = bits [8k+7:8k], selected by addr[1:0]. Halfword lane = addr[1] (bits [15:0] or [31:16]).
- Load extension: bit 7 (byte) or bit 15 (half) replicated when req_unsigned=0; zeros when 1. A word load passes through unchanged.
- Merge: only the addressed lane is replaced with wdata[7:0] or wdata[15:0]; all other bits keep the read value.
- WRITE (1 cycle): mem_write=1, mem_address and mem_write_data held stable. The memory commits at the closing edge. Next state is RESP.
- RESP (1 cycle): resp_valid=1, resp_rdata and resp_err driven. Next state is IDLE. There is no response backpressure.
- Latency from accept edge to resp_valid-high cycle:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput: a new request can be accepted at the edge ending RESP+1, i.e. req_ready is high again the cycle after RESP.
- mem_read and mem_write are never both 1. Outside READ/WRITE both are 0, and mem_address/mem_write_data are 0 in IDLE.
- Reset (async, any state, including mid-WRITE):
  - state=IDLE, all registers cleared.
  - Outputs: req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
  - A store interrupted by reset before its WRITE edge does not reach memory.

Test Plan:
- Word load at 0x100 (dmem[64]=4) → mem_read pulse 1 cycle after accept; resp_valid 2 cycles after accept with rdata=32'h4, err=0.
- Store byte 0xAB at 0x105 (word 0x104 = 5) → READ then WRITE with mem_write_data=32'h0000AB05; subsequent lbu 0x105 returns 0xAB, lb 0x105 returns 32'hFFFFFFAB.
- Store half 0x8001 at 0x10A, then lh 0x10A → 32'hFFFF8001; lhu → 32'h00008001; lw 0x108 → 32'h80010003.
- Misaligned lw 0x102, lh 0x101, size=11, and lw 0x1000 → each has resp_valid 1 cycle after accept with err=1, rdata=0, and no mem_read/mem_write.
- Word store 0xDEADBEEF at 0x110 → no READ cycle, mem_write one cycle after accept, resp 2 cycles after accept; back-to-back req_valid held high is accepted only when req_ready=1.
- Assert rst_n low during the READ of a sub-byte store → outputs go to reset values immediately, no mem_write occurs, and the memory word is unchanged on a later read.
